// File: rtl/iobus_out_dev_if.sv
// IO-bus and device-side signal bundle for the 8-bit output device responder.
// The master modport is the processor/bus plus the device; the slave modport is the responder.
interface iobus_out_dev_if;
  logic        iob_poweron;
  logic        iob_reset;
  logic        datao_clear;
  logic        datao_set;
  logic        cono_clear;
  logic        cono_set;
  logic        iob_fm_datai;
  logic        iob_fm_status;
  logic        rdi_pulse;
  logic [3:9]  ios;
  logic [0:35] iob_write;
  logic [1:7]  pi_req;
  logic [0:35] iob_read;
  logic        dr_split;
  logic        rdi_data;
  logic [0:7]  out_data;
  logic        out_strobe;
  logic        out_ack;

  modport master (
    output iob_poweron, iob_reset, datao_clear, datao_set, cono_clear, cono_set,
           iob_fm_datai, iob_fm_status, rdi_pulse, ios, iob_write, out_ack,
    input  pi_req, iob_read, dr_split, rdi_data, out_data, out_strobe
  );

  modport slave (
    input  iob_poweron, iob_reset, datao_clear, datao_set, cono_clear, cono_set,
           iob_fm_datai, iob_fm_status, rdi_pulse, ios, iob_write, out_ack,
    output pi_req, iob_read, dr_split, rdi_data, out_data, out_strobe
  );
endinterface

// File: rtl/iobus_out_dev.sv
// IO-bus responder for an 8-bit output device: CONO/DATAO/CONI/DATAI decode,
// strobe/ack byte hand-off with ack timeout, and PI request on completion.
module iobus_out_dev #(
  parameter logic [6:0]  DEVNO   = 7'o20,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic           clk,
  input  logic           reset,
  iobus_out_dev_if.slave bus
);

  typedef enum logic [1:0] {IDLE, STRB, WACK} state_t;

  localparam logic [15:0] TMR_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [0:2]  pia, pia_nx;
  logic        busy, busy_nx;
  logic        done, done_nx;
  logic        ovr, ovr_nx;
  logic [0:7]  data_buf, data_buf_nx;
  logic [15:0] tmr, tmr_nx;
  logic        strobe, strobe_nx;

  logic        sel;
  logic        bus_clr;
  logic [0:35] data_word, stat_word;
  logic        unused_ok;

  assign sel     = (bus.ios == DEVNO);
  assign bus_clr = bus.iob_reset | ~bus.iob_poweron;

  always_comb begin
    state_nx    = state;
    pia_nx      = pia;
    busy_nx     = busy;
    done_nx     = done;
    ovr_nx      = ovr;
    data_buf_nx = data_buf;
    tmr_nx      = tmr;
    strobe_nx   = 1'b0;

    case (state)
      IDLE: begin
        if (sel && bus.datao_clear)
          data_buf_nx = '0;
        if (sel && bus.datao_set) begin
          data_buf_nx = data_buf_nx | bus.iob_write[28:35];
          busy_nx     = 1'b1;
          done_nx     = 1'b0;
          state_nx    = STRB;
          strobe_nx   = 1'b1;
          tmr_nx      = '0;
        end
      end
      STRB: begin
        tmr_nx   = tmr + 16'd1;
        state_nx = WACK;
        if (sel && (bus.datao_set || bus.datao_clear))
          ovr_nx = 1'b1;
      end
      WACK: begin
        tmr_nx = tmr + 16'd1;
        if (sel && (bus.datao_set || bus.datao_clear))
          ovr_nx = 1'b1;
        if (bus.out_ack || (tmr >= TMR_LAST)) begin
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // CONO is applied last so it overrides any DATAO/FSM update in the same cycle.
    if (sel && bus.cono_clear) begin
      pia_nx    = '0;
      busy_nx   = 1'b0;
      done_nx   = 1'b0;
      ovr_nx    = 1'b0;
      state_nx  = IDLE;
      strobe_nx = 1'b0;
    end
    if (sel && bus.cono_set) begin
      busy_nx = busy_nx | bus.iob_write[31];
      done_nx = done_nx | bus.iob_write[32];
      pia_nx  = pia_nx  | bus.iob_write[33:35];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pia      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovr      <= 1'b0;
      data_buf <= '0;
      tmr      <= '0;
      strobe   <= 1'b0;
    end else if (bus_clr) begin
      state    <= IDLE;
      pia      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovr      <= 1'b0;
      data_buf <= '0;
      tmr      <= '0;
      strobe   <= 1'b0;
    end else begin
      state    <= state_nx;
      pia      <= pia_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      ovr      <= ovr_nx;
      data_buf <= data_buf_nx;
      tmr      <= tmr_nx;
      strobe   <= strobe_nx;
    end
  end

  always_comb begin
    data_word = '0;
    stat_word = '0;
    if (sel && bus.iob_fm_datai)
      data_word[28:35] = data_buf;
    if (sel && bus.iob_fm_status) begin
      stat_word[30]    = ovr;
      stat_word[31]    = busy;
      stat_word[32]    = done;
      stat_word[33:35] = pia;
    end
  end

  always_comb begin
    bus.pi_req = '0;
    for (int unsigned k = 1; k <= 7; k++)
      bus.pi_req[k] = done && (pia == 3'(k));
  end

  assign bus.iob_read   = data_word | stat_word;
  assign bus.out_data   = data_buf;
  assign bus.out_strobe = strobe;
  assign bus.dr_split   = 1'b0;
  assign bus.rdi_data   = 1'b0;

  assign unused_ok = ^{bus.rdi_pulse, bus.iob_write[0:27]};

endmodule

// File: tb/tb_iobus_out_dev.sv
// Bench for iobus_out_dev: scenario tasks with a byte scoreboard checked on each out_strobe.
module tb_iobus_out_dev;

  localparam logic [6:0]  DEV = 7'o20;
  localparam logic [6:0]  BAD = 7'o21;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic reset;

  iobus_out_dev_if bus ();

  iobus_out_dev #(.DEVNO(DEV), .TIMEOUT(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  logic [0:7] exp_q[$];
  logic [0:7] mon_exp;

  // Scoreboard: every strobe must match the oldest byte the bench expects to be sent.
  always @(negedge clk) begin
    if (bus.out_strobe === 1'b1) begin
      strobe_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe got data %0o required no strobe", bus.out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.out_data !== mon_exp) begin
          errors++;
          $display("FAIL strobe_data got %0o required %0o", bus.out_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic dc, input logic ds, input logic cc, input logic cs,
                       input logic [0:35] w, input logic [6:0] dev);
    bus.ios         = dev;
    bus.iob_write   = w;
    bus.datao_clear = dc;
    bus.datao_set   = ds;
    bus.cono_clear  = cc;
    bus.cono_set    = cs;
    tick();
    bus.datao_clear = 1'b0;
    bus.datao_set   = 1'b0;
    bus.cono_clear  = 1'b0;
    bus.cono_set    = 1'b0;
    bus.iob_write   = '0;
    bus.ios         = DEV;
  endtask

  task automatic read_data(output logic [0:35] v);
    bus.iob_fm_status = 1'b0;
    bus.iob_fm_datai  = 1'b1;
    #1;
    v = bus.iob_read;
    bus.iob_fm_datai  = 1'b0;
    bus.iob_fm_status = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    logic [0:35] v;
    reset = 1'b0;
    bus.iob_poweron = 1'b1; bus.iob_reset = 1'b0;
    bus.datao_clear = 1'b0; bus.datao_set = 1'b0;
    bus.cono_clear = 1'b0;  bus.cono_set = 1'b0;
    bus.iob_fm_datai = 1'b1; bus.iob_fm_status = 1'b1;
    bus.rdi_pulse = 1'b0; bus.ios = DEV; bus.iob_write = '0; bus.out_ack = 1'b0;
    #2;
    checks++; if (bus.iob_read !== 36'o0) begin errors++; $display("FAIL reset_read got %0o required 0", bus.iob_read); end
    checks++; if (bus.pi_req !== 7'b0) begin errors++; $display("FAIL reset_pi got %b required 0", bus.pi_req); end
    checks++; if ({bus.out_strobe, bus.out_data, bus.dr_split, bus.rdi_data} !== 11'b0) begin errors++; $display("FAIL reset_outs got %b required 0", {bus.out_strobe, bus.out_data, bus.dr_split, bus.rdi_data}); end
    @(negedge clk); reset = 1'b1;
    bus.iob_fm_datai = 1'b0;
    tick();
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 36'o15, DEV);
    exp_q.push_back(8'o42);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 36'o42, DEV);
    tick(); tick();
    checks++; if (bus.iob_read !== 36'o25) begin errors++; $display("FAIL pre_reset_status got %0o required 25", bus.iob_read); end
    #2; reset = 1'b0; bus.iob_fm_datai = 1'b1; #1;
    checks++; if (bus.iob_read !== 36'o0) begin errors++; $display("FAIL midwack_reset_read got %0o required 0", bus.iob_read); end
    checks++; if (bus.pi_req !== 7'b0) begin errors++; $display("FAIL midwack_reset_pi got %b required 0", bus.pi_req); end
    checks++; if ({bus.out_strobe, bus.out_data} !== 9'b0) begin errors++; $display("FAIL midwack_reset_out got %b required 0", {bus.out_strobe, bus.out_data}); end
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;
    checks++; if (bus.iob_read !== 36'o0) begin errors++; $display("FAIL held_reset_read got %0o required 0", bus.iob_read); end
    @(negedge clk); reset = 1'b1; bus.iob_fm_datai = 1'b0;
    tick(); tick();
    checks++; if (bus.iob_read !== 36'o0) begin errors++; $display("FAIL post_reset_coni got %0o required 0", bus.iob_read); end
  endtask

  task automatic test_program_send;
    logic [0:35] v;
    int s0;
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 36'o5, DEV);
    checks++; if (bus.iob_read !== 36'o5) begin errors++; $display("FAIL cono_pia got %0o required 5", bus.iob_read); end
    s0 = strobe_cnt;
    exp_q.push_back(8'o101);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 36'o101, DEV);
    checks++; if (bus.out_strobe !== 1'b1) begin errors++; $display("FAIL strobe_latency got %b required 1", bus.out_strobe); end
    checks++; if (bus.out_data !== 8'o101) begin errors++; $display("FAIL out_data got %0o required 101", bus.out_data); end
    tick();
    checks++; if (bus.out_strobe !== 1'b0) begin errors++; $display("FAIL strobe_width got %b required 0", bus.out_strobe); end
    tick(); tick();
    bus.out_ack = 1'b1; #1;
    checks++; if (bus.iob_read !== 36'o25) begin errors++; $display("FAIL before_ack_status got %0o required 25", bus.iob_read); end
    tick();
    bus.out_ack = 1'b0;
    checks++; if (bus.iob_read !== 36'o15) begin errors++; $display("FAIL done_status got %0o required 15", bus.iob_read); end
    checks++; if (bus.pi_req !== 7'b0000100) begin errors++; $display("FAIL pi_req5 got %b required 0000100", bus.pi_req); end
    read_data(v);
    checks++; if (v !== 36'o101) begin errors++; $display("FAIL datai got %0o required 101", v); end
    checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL strobe_count got %0d required 1", strobe_cnt - s0); end
  endtask

  task automatic test_timeout;
    int done_at;
    logic busy_before, busy_at_done;
    done_at = -1; busy_before = 1'b0; busy_at_done = 1'b1;
    exp_q.push_back(8'o353);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 36'o252, DEV);
    checks++; if (bus.out_strobe !== 1'b1) begin errors++; $display("FAIL tmo_strobe got %b required 1", bus.out_strobe); end
    for (int i = 1; i <= 40 && done_at < 0; i++) begin
      tick();
      if (bus.iob_read[32] === 1'b1) begin
        done_at = i;
        busy_at_done = bus.iob_read[31];
      end else begin
        busy_before = bus.iob_read[31];
      end
    end
    checks++; if (done_at != int'(TMO)) begin errors++; $display("FAIL timeout_cycles got %0d required %0d", done_at, TMO); end
    checks++; if ({busy_before, busy_at_done} !== 2'b10) begin errors++; $display("FAIL timeout_busy got %b required 10", {busy_before, busy_at_done}); end
    checks++; if (bus.pi_req !== 7'b0000100) begin errors++; $display("FAIL timeout_pi got %b required 0000100", bus.pi_req); end
  endtask

  task automatic test_overrun;
    logic [0:35] v;
    exp_q.push_back(8'o101);
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 36'o101, DEV);
    tick();
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 36'o377, DEV);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 36'o0, DEV);
    checks++; if (bus.out_data !== 8'o101) begin errors++; $display("FAIL ovr_buf got %0o required 101", bus.out_data); end
    checks++; if (bus.iob_read !== 36'o65) begin errors++; $display("FAIL ovr_status got %0o required 65", bus.iob_read); end
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;
    checks++; if (bus.iob_read !== 36'o55) begin errors++; $display("FAIL ovr_sticky got %0o required 55", bus.iob_read); end
    read_data(v);
    checks++; if (v !== 36'o101) begin errors++; $display("FAIL ovr_datai got %0o required 101", v); end
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 36'o0, DEV);
    checks++; if (bus.iob_read !== 36'o0) begin errors++; $display("FAIL cono_clear got %0o required 0", bus.iob_read); end
    checks++; if (bus.pi_req !== 7'b0) begin errors++; $display("FAIL cono_clear_pi got %b required 0", bus.pi_req); end
  endtask

  task automatic test_select;
    logic [0:35] v;
    int s0;
    s0 = strobe_cnt;
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 36'o77, BAD);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 36'o377, BAD);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 36'o0, BAD);
    tick(); tick();
    bus.ios = BAD; bus.iob_fm_datai = 1'b1; #1;
    checks++; if (bus.iob_read !== 36'o0) begin errors++; $display("FAIL nosel_read got %0o required 0", bus.iob_read); end
    bus.ios = DEV; #1;
    checks++; if (bus.iob_read !== 36'o101) begin errors++; $display("FAIL nosel_state got %0o required 101", bus.iob_read); end
    bus.iob_fm_datai = 1'b0;
    checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL nosel_strobe got %0d required %0d", strobe_cnt, s0); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 36'o17, DEV);
    checks++; if (bus.pi_req !== 7'b0000001) begin errors++; $display("FAIL pi_req7 got %b required 0000001", bus.pi_req); end
    pulse(1'b0, 1'b0, 1'b1, 1'b1, 36'o3, DEV);
    checks++; if (bus.iob_read !== 36'o3) begin errors++; $display("FAIL clr_set_same got %0o required 3", bus.iob_read); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 36'o10, DEV);
    checks++; if (bus.pi_req !== 7'b0010000) begin errors++; $display("FAIL pi_req3 got %b required 0010000", bus.pi_req); end
    read_data(v);
    checks++; if (v !== 36'o101) begin errors++; $display("FAIL sel_datai got %0o required 101", v); end
  endtask

  task automatic test_bus_reset;
    logic [0:35] v;
    bus.iob_reset = 1'b1; tick(); bus.iob_reset = 1'b0;
    checks++; if (bus.iob_read !== 36'o0) begin errors++; $display("FAIL iob_reset_status got %0o required 0", bus.iob_read); end
    read_data(v);
    checks++; if (v !== 36'o0) begin errors++; $display("FAIL iob_reset_buf got %0o required 0", v); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 36'o15, DEV);
    bus.iob_poweron = 1'b0; tick(); bus.iob_poweron = 1'b1;
    checks++; if (bus.iob_read !== 36'o0) begin errors++; $display("FAIL poweron_clear got %0o required 0", bus.iob_read); end
  endtask

  initial begin
    test_reset();
    test_program_send();
    test_timeout();
    test_overrun();
    test_select();
    test_bus_reset();
    tick(); tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL missing_strobes got %0d pending required 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
